// File: rtl/test_sequencer.sv
// Memory test sequencer. It issues a write sweep, a read sweep, or a write sweep
// followed by a read sweep, and checks each read word against pattern ^ address.
module test_sequencer #(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 32
) (
    input  logic              clk_mem_i,
    input  logic              rst_mem_i,
    input  logic              test_start_i,
    input  logic [ADDR_W-1:0] start_addr_i,
    input  logic [7:0]        addr_step_i,
    input  logic [CNT_W-1:0]  word_cnt_i,
    input  logic [1:0]        test_mode_i,
    input  logic [31:0]       pattern_i,
    output logic              cmd_valid_o,
    input  logic              cmd_ready_i,
    output logic              cmd_write_o,
    output logic [ADDR_W-1:0] cmd_address_o,
    output logic [31:0]       cmd_writedata_o,
    input  logic              rd_valid_i,
    input  logic [31:0]       rd_data_i,
    output logic              busy_o,
    output logic              test_finished_o,
    output logic [CNT_W-1:0]  wr_cnt_o,
    output logic [CNT_W-1:0]  rd_cnt_o,
    output logic [CNT_W-1:0]  err_cnt_o,
    output logic [ADDR_W-1:0] first_err_addr_o
);
    typedef enum logic [1:0] {IDLE = 2'd0, WR_PHASE = 2'd1, RD_PHASE = 2'd2, RD_DRAIN = 2'd3} state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W:0]   OUT_ONE = {{CNT_W{1'b0}}, 1'b1};

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] base_q, cmd_addr, rsp_addr, step_ext;
    logic [7:0]        step_q;
    logic [CNT_W-1:0]  cnt_q, cmd_idx;
    logic [1:0]        mode_q;
    logic [31:0]       pat_q;
    logic [CNT_W:0]    outst;
    logic [CNT_W-1:0]  wr_cnt, rd_cnt, err_cnt;
    logic [ADDR_W-1:0] first_err;
    logic              finished;
    logic              start_acc, cmd_hs, rd_hs, last_cmd, rsp_acc, mismatch;

    assign step_ext  = ADDR_W'(step_q);
    assign start_acc = test_start_i && (state == IDLE);
    assign cmd_hs    = cmd_valid_o && cmd_ready_i;
    assign rd_hs     = cmd_hs && (state == RD_PHASE);
    assign last_cmd  = (cmd_idx == cnt_q - CNT_ONE);
    // Responses only count while reads are outstanding; strays are dropped.
    assign rsp_acc   = rd_valid_i && (outst != '0);
    assign mismatch  = rsp_acc && (rd_data_i != (pat_q ^ 32'(rsp_addr)));

    always_ff @(posedge clk_mem_i) begin
        if (!rst_mem_i) state <= IDLE;
        else            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (start_acc && word_cnt_i != '0)
                          state_nxt = (test_mode_i == 2'd1) ? RD_PHASE : WR_PHASE;
            WR_PHASE: if (cmd_hs && last_cmd)
                          state_nxt = (mode_q == 2'd0) ? IDLE : RD_PHASE;
            RD_PHASE: if (cmd_hs && last_cmd) state_nxt = RD_DRAIN;
            RD_DRAIN: if (rsp_acc && outst == OUT_ONE) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_comb begin
        cmd_valid_o = (state == WR_PHASE) || (state == RD_PHASE);
        cmd_write_o = (state == WR_PHASE);
        busy_o      = (state != IDLE);
    end

    assign cmd_address_o    = cmd_addr;
    assign cmd_writedata_o  = pat_q ^ 32'(cmd_addr);
    assign test_finished_o  = finished;
    assign wr_cnt_o         = wr_cnt;
    assign rd_cnt_o         = rd_cnt;
    assign err_cnt_o        = err_cnt;
    assign first_err_addr_o = first_err;

    // Command and response address generators run independently so reads can
    // be issued ahead of their responses.
    always_ff @(posedge clk_mem_i) begin
        if (start_acc) begin
            base_q   <= start_addr_i;
            step_q   <= addr_step_i;
            cnt_q    <= word_cnt_i;
            mode_q   <= test_mode_i;
            pat_q    <= pattern_i;
            cmd_idx  <= '0;
            cmd_addr <= start_addr_i;
            rsp_addr <= start_addr_i;
        end else begin
            if (cmd_hs) begin
                if (last_cmd) begin
                    cmd_idx  <= '0;
                    cmd_addr <= base_q;
                end else begin
                    cmd_idx  <= cmd_idx + CNT_ONE;
                    cmd_addr <= cmd_addr + step_ext;
                end
            end
            if (rsp_acc) rsp_addr <= rsp_addr + step_ext;
        end
    end

    always_ff @(posedge clk_mem_i) begin
        if (!rst_mem_i) begin
            outst     <= '0;
            wr_cnt    <= '0;
            rd_cnt    <= '0;
            err_cnt   <= '0;
            first_err <= '0;
            finished  <= 1'b0;
        end else if (start_acc) begin
            outst     <= '0;
            wr_cnt    <= '0;
            rd_cnt    <= '0;
            err_cnt   <= '0;
            first_err <= '0;
            finished  <= (word_cnt_i == '0);
        end else begin
            if (state != IDLE && state_nxt == IDLE) finished <= 1'b1;
            if (cmd_hs && state == WR_PHASE) wr_cnt <= wr_cnt + CNT_ONE;
            case ({rd_hs, rsp_acc})
                2'b10:   outst <= outst + OUT_ONE;
                2'b01:   outst <= outst - OUT_ONE;
                default: ;
            endcase
            if (rsp_acc) rd_cnt <= rd_cnt + CNT_ONE;
            if (mismatch) begin
                if (err_cnt != '1) err_cnt <= err_cnt + CNT_ONE;
                if (err_cnt == '0) first_err <= rsp_addr;
            end
        end
    end
endmodule

// File: tb/tb_test_sequencer.sv
// Scoreboard bench for test_sequencer: reference model queues expected commands
// and final results, a memory model answers reads, a monitor checks both.
module tb_test_sequencer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] start_addr = '0;
    logic [7:0]  addr_step = '0;
    logic [31:0] word_cnt = '0;
    logic [1:0]  test_mode = '0;
    logic [31:0] pattern = '0;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_address, cmd_writedata;
    logic        rd_valid;
    logic [31:0] rd_data;
    logic        busy, test_finished;
    logic [31:0] wr_cnt, rd_cnt, err_cnt, first_err_addr;

    always #5 clk = ~clk;

    test_sequencer #(.ADDR_W(32), .CNT_W(32)) dut (
        .clk_mem_i(clk), .rst_mem_i(rst_n), .test_start_i(start),
        .start_addr_i(start_addr), .addr_step_i(addr_step), .word_cnt_i(word_cnt),
        .test_mode_i(test_mode), .pattern_i(pattern),
        .cmd_valid_o(cmd_valid), .cmd_ready_i(cmd_ready), .cmd_write_o(cmd_write),
        .cmd_address_o(cmd_address), .cmd_writedata_o(cmd_writedata),
        .rd_valid_i(rd_valid), .rd_data_i(rd_data), .busy_o(busy),
        .test_finished_o(test_finished), .wr_cnt_o(wr_cnt), .rd_cnt_o(rd_cnt),
        .err_cnt_o(err_cnt), .first_err_addr_o(first_err_addr)
    );

    typedef struct {bit w; bit [31:0] a; bit [31:0] d;} cmd_t;
    typedef struct {bit [31:0] wr; bit [31:0] rd; bit [31:0] err; bit [31:0] first;} res_t;
    typedef struct {bit [31:0] a; int due;} pend_t;

    cmd_t      exp_cmd[$];
    res_t      exp_res[$];
    pend_t     pend[$];
    bit [31:0] mem [bit [31:0]];
    int        tests = 0, fails = 0;
    int        ready_mode = 0, stray_req = 0, cyc = 0, hs_count = 0;
    bit        resp_en = 1'b1, corrupt_en = 1'b0;
    bit [31:0] corrupt_addr = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic bit [31:0] mem_val(input bit [31:0] a);
        if (mem.exists(a)) return mem[a];
        return (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
    endfunction

    // Memory: writes land on handshake, reads come back in order after 1-4+ cycles.
    initial begin
        pend_t p;
        cmd_ready = 1'b0;
        rd_valid  = 1'b0;
        rd_data   = '0;
        forever begin
            @(negedge clk);
            if (rst_n && cmd_valid && cmd_ready) begin
                if (cmd_write) mem[cmd_address] = cmd_writedata;
                else if (resp_en) begin
                    p.a = cmd_address;
                    p.due = cyc + int'($urandom_range(0, 3));
                    pend.push_back(p);
                end
            end
            @(posedge clk);
            #1;
            cyc++;
            if (ready_mode == 0)      cmd_ready = 1'b1;
            else if (ready_mode == 1) cmd_ready = ~cmd_ready;
            else                      cmd_ready = 1'($urandom_range(0, 1));
            rd_valid = 1'b0;
            if (stray_req > 0) begin
                rd_valid = 1'b1;
                rd_data  = $urandom;
                stray_req--;
            end else if (pend.size() > 0 && cyc >= pend[0].due && $urandom_range(0, 3) != 0) begin
                rd_valid = 1'b1;
                rd_data  = mem_val(pend[0].a) ^ ((corrupt_en && pend[0].a == corrupt_addr) ? 32'h1 : 32'h0);
                void'(pend.pop_front());
            end
        end
    end

    // Monitor: command handshakes, stall stability, and results on finished rising.
    initial begin
        bit   pv = 1'b0, pr = 1'b0, pf = 1'b0;
        cmd_t pc, e;
        res_t r;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (pv && !pr) begin
                    check("stall_valid", cmd_valid, 1);
                    check("stall_write", cmd_write, pc.w);
                    check("stall_addr", cmd_address, pc.a);
                    check("stall_data", cmd_writedata, pc.d);
                end
                if (cmd_valid && cmd_ready) begin
                    hs_count++;
                    if (exp_cmd.size() == 0) begin
                        check("unexpected_cmd", cmd_address, 32'hDEAD_BEEF ^ cmd_address ^ 32'h1);
                    end else begin
                        e = exp_cmd.pop_front();
                        check("cmd_write", cmd_write, e.w);
                        check("cmd_addr", cmd_address, e.a);
                        if (e.w) check("cmd_data", cmd_writedata, e.d);
                    end
                end
                if (test_finished && !pf) begin
                    if (exp_res.size() == 0) begin
                        check("unexpected_finish", test_finished, 0);
                    end else begin
                        r = exp_res.pop_front();
                        check("wr_cnt", wr_cnt, r.wr);
                        check("rd_cnt", rd_cnt, r.rd);
                        check("err_cnt", err_cnt, r.err);
                        check("first_err_addr", first_err_addr, r.first);
                        check("busy_at_finish", busy, 0);
                    end
                end
            end
            pv = rst_n && cmd_valid;
            pr = cmd_ready;
            pc.w = cmd_write; pc.a = cmd_address; pc.d = cmd_writedata;
            pf = rst_n && test_finished;
        end
    end

    task automatic do_reset();
        @(posedge clk); #2 rst_n = 1'b0;
        @(posedge clk); #2 rst_n = 1'b1;
    endtask

    // Reference model: word k lives at sa + k*step (mod 2^32), data is pat ^ address.
    task automatic model(input int mode, input bit [31:0] sa, input int step, input int cnt,
                         input bit [31:0] pat, input bit cen, input bit [31:0] ca, input bit keep);
        res_t      r = '{0, 0, 0, 0};
        cmd_t      c;
        bit [31:0] a, got;
        for (int k = 0; k < cnt; k++) begin
            a = sa + 32'(k) * 32'(step);
            if (mode != 1) begin
                c.w = 1'b1; c.a = a; c.d = pat ^ a;
                exp_cmd.push_back(c);
                r.wr++;
            end
        end
        for (int k = 0; k < cnt; k++) begin
            a = sa + 32'(k) * 32'(step);
            if (mode != 0) begin
                c.w = 1'b0; c.a = a; c.d = '0;
                exp_cmd.push_back(c);
                got = ((mode == 1) ? mem_val(a) : (pat ^ a)) ^ ((cen && a == ca) ? 32'h1 : 32'h0);
                r.rd++;
                if (got != (pat ^ a)) begin
                    if (r.err == 0) r.first = a;
                    r.err++;
                end
            end
        end
        if (keep) exp_res.push_back(r);
    endtask

    task automatic issue_start(input int mode, input bit [31:0] sa, input int step,
                               input int cnt, input bit [31:0] pat);
        @(posedge clk); #2;
        start = 1'b1; test_mode = 2'(mode); start_addr = sa;
        addr_step = 8'(step); word_cnt = 32'(cnt); pattern = pat;
        @(posedge clk); #2;
        start = 1'b0;
        test_mode = 2'($urandom_range(0, 3)); start_addr = $urandom;
        addr_step = 8'($urandom); word_cnt = $urandom; pattern = $urandom;
    endtask

    task automatic run_test(input int mode, input bit [31:0] sa, input int step, input int cnt,
                            input bit [31:0] pat, input int rdy, input bit cen,
                            input bit [31:0] ca, input bit dbl);
        int n = 0;
        if (test_finished) do_reset();
        ready_mode = rdy; corrupt_en = cen; corrupt_addr = ca;
        model(mode, sa, step, cnt, pat, cen, ca, 1'b1);
        issue_start(mode, sa, step, cnt, pat);
        @(negedge clk);
        check("valid_after_start", cmd_valid, (cnt != 0) ? 1 : 0);
        check("busy_after_start", busy, (cnt != 0) ? 1 : 0);
        check("finished_after_start", test_finished, (cnt == 0) ? 1 : 0);
        if (dbl) begin
            @(posedge clk); #2;
            start = 1'b1; test_mode = 2'd0; word_cnt = 32'd1; start_addr = 32'h55;
            @(posedge clk); #2 start = 1'b0;
        end
        while (!test_finished && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) begin
            tests++; fails++;
            $display("FAIL finish_timeout: got no finish expected finish within 3000 cycles");
        end
        repeat (3) @(negedge clk);
        check("cmds_left", exp_cmd.size(), 0);
        check("results_left", exp_res.size(), 0);
        check("finished_held", test_finished, 1);
    endtask

    initial begin
        int        md, cnt, st, h0, n;
        bit [31:0] sa;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check("rst_valid", cmd_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_finished", test_finished, 0);
        check("rst_wr", wr_cnt, 0);
        check("rst_rd", rd_cnt, 0);
        check("rst_err", err_cnt, 0);
        check("rst_first", first_err_addr, 0);

        run_test(2, 32'h100, 1, 4, 32'hA5A5_A5A5, 0, 1'b0, 0, 1'b0);
        run_test(2, 32'h100, 1, 4, 32'hA5A5_A5A5, 0, 1'b1, 32'h102, 1'b0);
        run_test(0, 32'hFFFF_FFFE, 2, 3, 32'h1234_5678, 1, 1'b0, 0, 1'b0);
        for (int m = 0; m < 4; m++) run_test(m, $urandom, 3, 0, $urandom, 0, 1'b0, 0, 1'b0);
        run_test(2, 32'h40, 4, 6, 32'hCAFE_F00D, 2, 1'b0, 0, 1'b1);
        run_test(1, 32'h40, 4, 6, 32'h0BAD_0BAD, 2, 1'b0, 0, 1'b0);

        for (int t = 0; t < 24; t++) begin
            md  = int'($urandom_range(0, 3));
            cnt = int'($urandom_range(0, 10));
            st  = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, 255));
            sa  = ($urandom_range(0, 1) != 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 15))) : $urandom;
            run_test(md, sa, st, cnt, $urandom, int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)),
                     sa + 32'($urandom_range(0, 9)) * 32'(st), 1'b0);
        end

        // Reset in the middle of a read sweep, then stray responses.
        if (test_finished) do_reset();
        ready_mode = 0; corrupt_en = 1'b0;
        model(1, 32'h2000, 1, 8, 32'h7777_0000, 1'b0, 0, 1'b0);
        h0 = hs_count;
        issue_start(1, 32'h2000, 1, 8, 32'h7777_0000);
        n = 0;
        while (hs_count < h0 + 3 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            tests++; fails++;
            $display("FAIL mid_reset_wait: got %0d handshakes expected 3", hs_count - h0);
        end
        resp_en = 1'b0;
        @(posedge clk); #2 rst_n = 1'b0;
        pend.delete();
        @(posedge clk); #2 rst_n = 1'b1;
        exp_cmd.delete();
        @(negedge clk);
        check("mid_rst_valid", cmd_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_finished", test_finished, 0);
        check("mid_rst_rd", rd_cnt, 0);
        check("mid_rst_first", first_err_addr, 0);
        resp_en = 1'b1;
        stray_req = 2;
        repeat (5) @(negedge clk);
        check("stray_rd", rd_cnt, 0);
        check("stray_err", err_cnt, 0);
        check("stray_wr", wr_cnt, 0);
        check("stray_busy", busy, 0);
        check("stray_finished", test_finished, 0);

        run_test(2, 32'h3000, 8, 5, 32'h0F0F_F0F0, 2, 1'b1, 32'h3010, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        fails++;
        $display("FAIL watchdog: got no completion expected completion before time limit");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog");
    end
endmodule
